// File: rtl/xor_stream_parity_pkg.sv
// Shared types, default parameters and the parity helper for the streaming
// XOR parity engine.
package xor_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ODD       = 0;
  localparam int DEF_MAX_BEATS = 16;

  // Widest word parity_f accepts; callers zero-extend, which leaves the XOR unchanged.
  localparam int PAR_MAX_W = 1024;

  function automatic logic parity_f(input logic [PAR_MAX_W-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/xor_stream_parity_if.sv
// Beat-in / result-out bundle for xor_stream_parity. The master side feeds beats
// and accepts results; the slave side is the engine.
interface xor_stream_parity_if
  import xor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = $clog2(DEF_MAX_BEATS + 1)
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_word;
  logic              m_parity;
  logic [CNT_W-1:0]  m_beats;
  logic              m_err;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_word, m_parity, m_beats, m_err
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_word, m_parity, m_beats, m_err
  );

endinterface

// File: rtl/xor_stream_parity_fold_acc.sv
// Running XOR / beat-count / overflow accumulator for one packet. Exposes the
// packet totals as they would stand with the presented beat folded in.
module xor_fold_acc
  import xor_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] word_o,
  output logic [CNT_W-1:0]  beats_o,
  output logic              err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              at_max;

  assign at_max  = (cnt_q == MAX_CNT);
  assign word_o  = acc_q ^ data_i;
  assign beats_o = at_max ? cnt_q : cnt_q + CNT_W'(1);
  assign err_o   = err_q | at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // A final beat hands its totals to the output register and restarts the fold.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear_i || (step_i && last_i)) begin
      acc_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (step_i) begin
      acc_d = word_o;
      cnt_d = beats_o;
      err_d = err_o;
    end
  end

endmodule

// File: rtl/xor_stream_parity.sv
// Streaming XOR-reduction engine: folds a packet of beats into one word plus
// parity, beat count and overflow flag, held on a registered result port.
module xor_stream_parity
  import xor_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int ODD       = DEF_ODD,
  parameter  int MAX_BEATS = DEF_MAX_BEATS,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 clear,
  xor_stream_parity_if.slave  bus
);

  localparam logic ODD_BIT = 1'(ODD);

  state_e state_q, state_d;

  logic              s_xfer;
  logic              m_acc;
  logic              pkt_done;

  logic [DATA_W-1:0]    fold_word;
  logic [CNT_W-1:0]     fold_beats;
  logic                 fold_err;
  logic [PAR_MAX_W-1:0] fold_wide;

  logic [DATA_W-1:0] word_q, word_d;
  logic              parity_q, parity_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic              err_q, err_d;

  assign s_xfer    = bus.s_valid & bus.s_ready;
  assign m_acc     = bus.m_valid & bus.m_ready;
  assign pkt_done  = s_xfer & bus.s_last & ~clear;
  assign fold_wide = PAR_MAX_W'(fold_word);

  xor_fold_acc #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS),
    .CNT_W     (CNT_W)
  ) u_fold (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .step_i  (s_xfer),
    .last_i  (bus.s_last),
    .data_i  (bus.s_data),
    .word_o  (fold_word),
    .beats_o (fold_beats),
    .err_o   (fold_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // clear wins over both a completing beat and a result accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (pkt_done) state_d = HOLD;
      HOLD:    if (m_acc)    state_d = ACCUM;
      default:               state_d = ACCUM;
    endcase
    if (clear) state_d = ACCUM;
  end

  always_comb begin
    bus.s_ready = (state_q == ACCUM);
    bus.m_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      parity_q <= ODD_BIT;
      beats_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      word_q   <= word_d;
      parity_q <= parity_d;
      beats_q  <= beats_d;
      err_q    <= err_d;
    end
  end

  // Result fields keep their last value after acceptance or clear.
  always_comb begin
    word_d   = word_q;
    parity_d = parity_q;
    beats_d  = beats_q;
    err_d    = err_q;
    if (pkt_done) begin
      word_d   = fold_word;
      parity_d = parity_f(fold_wide, ODD_BIT);
      beats_d  = fold_beats;
      err_d    = fold_err;
    end
  end

  assign bus.m_word   = word_q;
  assign bus.m_parity = parity_q;
  assign bus.m_beats  = beats_q;
  assign bus.m_err    = err_q;

endmodule

// File: tb/tb_xor_stream_parity.sv
// Self-checking bench: two engines (even/16-beat and odd/4-beat) share one input
// stream and are compared against a packet-level model and a directed table.
module tb_xor_stream_parity;

  localparam int DW    = 8;
  localparam int MAX_A = 16;
  localparam int MAX_B = 4;
  localparam int CNT_A = 5;
  localparam int CNT_B = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  xor_stream_parity_if #(.DATA_W(DW), .CNT_W(CNT_A)) ifA ();
  xor_stream_parity_if #(.DATA_W(DW), .CNT_W(CNT_B)) ifB ();

  xor_stream_parity #(.DATA_W(DW), .ODD(0), .MAX_BEATS(MAX_A)) dutA (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifA)
  );

  xor_stream_parity #(.DATA_W(DW), .ODD(1), .MAX_BEATS(MAX_B)) dutB (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifB)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         l;
    bit         mr;
    bit         clr;
    bit         eMv;
    logic [7:0] eWord;
    bit         eParA;
    int         eBeatsA;
    bit         eErrA;
    bit         eParB;
    int         eBeatsB;
    bit         eErrB;
  } vec_t;

  int nVec  = 0;
  int nMiss = 0;

  // Packet-level model: beats of the open packet plus the last completed result.
  bit         mHold;
  logic [7:0] pktQ[$];
  logic [7:0] resWord;
  int         resN;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setInputs(input bit v, input logic [7:0] d, input bit l, input bit mr, input bit clr);
    ifA.s_valid = v;  ifA.s_data = d;  ifA.s_last = l;  ifA.m_ready = mr;
    ifB.s_valid = v;  ifB.s_data = d;  ifB.s_last = l;  ifB.m_ready = mr;
    clear = clr;
  endtask

  task automatic modelReset();
    mHold = 1'b0;
    pktQ.delete();
    resWord = 8'h00;
    resN = 0;
  endtask

  task automatic modelUpdate(input bit v, input logic [7:0] d, input bit l, input bit mr, input bit clr);
    logic [7:0] w;
    if (clr) begin
      mHold = 1'b0;
      pktQ.delete();
    end else if (!mHold && v) begin
      pktQ.push_back(d);
      if (l) begin
        w = 8'h00;
        foreach (pktQ[k]) w = w ^ pktQ[k];
        resWord = w;
        resN = pktQ.size();
        pktQ.delete();
        mHold = 1'b1;
      end
    end else if (mHold && mr) begin
      mHold = 1'b0;
    end
  endtask

  task automatic checkOutput();
    int bA, bB;
    bA = (resN > MAX_A) ? MAX_A : resN;
    bB = (resN > MAX_B) ? MAX_B : resN;
    cmp("A.s_ready",  32'(ifA.s_ready),  32'(!mHold));
    cmp("A.m_valid",  32'(ifA.m_valid),  32'(mHold));
    cmp("A.m_word",   32'(ifA.m_word),   32'(resWord));
    cmp("A.m_parity", 32'(ifA.m_parity), 32'(^resWord));
    cmp("A.m_beats",  32'(ifA.m_beats),  32'(bA));
    cmp("A.m_err",    32'(ifA.m_err),    32'(resN > MAX_A));
    cmp("B.s_ready",  32'(ifB.s_ready),  32'(!mHold));
    cmp("B.m_valid",  32'(ifB.m_valid),  32'(mHold));
    cmp("B.m_word",   32'(ifB.m_word),   32'(resWord));
    cmp("B.m_parity", 32'(ifB.m_parity), 32'(~^resWord));
    cmp("B.m_beats",  32'(ifB.m_beats),  32'(bB));
    cmp("B.m_err",    32'(ifB.m_err),    32'(resN > MAX_B));
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit l, input bit mr, input bit clr);
    setInputs(v, d, l, mr, clr);
    @(posedge clk);
    modelUpdate(v, d, l, mr, clr);
    #2;
    nVec++;
    checkOutput();
  endtask

  task automatic checkTable(input vec_t t, input int idx);
    cmp($sformatf("tbl%0d s_ready", idx),  32'(ifA.s_ready),  32'(!t.eMv));
    cmp($sformatf("tbl%0d m_valid", idx),  32'(ifA.m_valid),  32'(t.eMv));
    cmp($sformatf("tbl%0d A.word", idx),   32'(ifA.m_word),   32'(t.eWord));
    cmp($sformatf("tbl%0d A.parity", idx), 32'(ifA.m_parity), 32'(t.eParA));
    cmp($sformatf("tbl%0d A.beats", idx),  32'(ifA.m_beats),  32'(t.eBeatsA));
    cmp($sformatf("tbl%0d A.err", idx),    32'(ifA.m_err),    32'(t.eErrA));
    cmp($sformatf("tbl%0d B.parity", idx), 32'(ifB.m_parity), 32'(t.eParB));
    cmp($sformatf("tbl%0d B.beats", idx),  32'(ifB.m_beats),  32'(t.eBeatsB));
    cmp($sformatf("tbl%0d B.err", idx),    32'(ifB.m_err),    32'(t.eErrB));
  endtask

  vec_t tbl[$];

  initial begin
    bit rv, rl, rmr, rclr;
    logic [7:0] rd;

    // v, d, l, mr, clr | m_valid, word, parA, beatsA, errA, parB, beatsB, errB
    tbl.push_back('{1, 8'h3C, 0, 1, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 8'h0F, 0, 1, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 8'hA5, 1, 1, 0,  1, 8'h96, 0, 3, 0, 1, 3, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 0,  0, 8'h96, 0, 3, 0, 1, 3, 0});
    tbl.push_back('{1, 8'h01, 1, 0, 0,  1, 8'h01, 1, 1, 0, 0, 1, 0});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1, 8'h55, 0, 0, 0,  1, 8'h01, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 8'h55, 0, 1, 0,  0, 8'h01, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 8'h55, 0, 1, 0,  0, 8'h01, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 8'hAA, 1, 1, 0,  1, 8'hFF, 0, 2, 0, 1, 2, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 0,  0, 8'hFF, 0, 2, 0, 1, 2, 0});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1, 8'hFF, 0, 1, 0,  0, 8'hFF, 0, 2, 0, 1, 2, 0});
    tbl.push_back('{1, 8'hFF, 1, 1, 0,  1, 8'h00, 0, 6, 0, 1, 4, 1});
    tbl.push_back('{0, 8'h00, 0, 1, 0,  0, 8'h00, 0, 6, 0, 1, 4, 1});
    tbl.push_back('{1, 8'h12, 0, 1, 0,  0, 8'h00, 0, 6, 0, 1, 4, 1});
    tbl.push_back('{1, 8'h34, 1, 1, 0,  1, 8'h26, 1, 2, 0, 0, 2, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 0,  0, 8'h26, 1, 2, 0, 0, 2, 0});
    tbl.push_back('{1, 8'h11, 0, 1, 0,  0, 8'h26, 1, 2, 0, 0, 2, 0});
    tbl.push_back('{1, 8'h22, 0, 1, 1,  0, 8'h26, 1, 2, 0, 0, 2, 0});
    tbl.push_back('{1, 8'h44, 1, 0, 0,  1, 8'h44, 0, 1, 0, 1, 1, 0});
    tbl.push_back('{0, 8'h00, 0, 0, 1,  0, 8'h44, 0, 1, 0, 1, 1, 0});
    tbl.push_back('{0, 8'h00, 0, 0, 0,  0, 8'h44, 0, 1, 0, 1, 1, 0});

    setInputs(0, 8'h00, 0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    checkOutput();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr, tbl[i].clr);
      checkTable(tbl[i], i);
    end

    // Asynchronous reset while a result is being held.
    applyStimulus(1, 8'hC3, 1, 0, 0);
    cmp("pre-reset m_valid", 32'(ifA.m_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    setInputs(0, 8'h00, 0, 0, 0);
    @(posedge clk);
    #2;
    checkOutput();
    rst_n = 1'b1;
    applyStimulus(1, 8'h5A, 1, 0, 0);
    cmp("post-reset word", 32'(ifA.m_word), 32'h5A);

    // Randomised traffic; the later stretch uses long packets to overflow both engines.
    for (int k = 0; k < 600; k++) begin
      rv   = ($urandom_range(0, 3) != 0);
      rd   = 8'($urandom);
      rl   = ($urandom_range(0, (k < 300) ? 3 : 24) == 0);
      rmr  = ($urandom_range(0, 2) != 0);
      rclr = ($urandom_range(0, 47) == 0);
      applyStimulus(rv, rd, rl, rmr, rclr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/xor_stream_parity.md
Name: xor_stream_parity

Overview:
- Streaming XOR-reduction engine; the sequential successor to the team's combinational XOR gate.
- Accepts a packet of DATA_W-bit beats over a valid/ready handshake.
- Folds all beats of the packet into one XOR word, and derives a parity bit of selectable sense.
- Presents the result with beat count and overflow flag on a registered valid/ready output; used ahead of link-integrity checkers.

Parameters:
- DATA_W, 8: beat width in bits, ≥1.
- ODD, 0: parity sense; 0 = even (m_parity = XOR of all bits), 1 = odd (inverted).
- MAX_BEATS, 16: maximum legal beats per packet, ≥1. CNT_W = $clog2(MAX_BEATS+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; drops any packet and pending result.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  DATA_W  input beat.
- s_last  in  1  final beat of packet.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted.
- m_word  out  DATA_W  XOR of all beats in packet.
- m_parity  out  1  (^m_word) ^ ODD.
- m_beats  out  CNT_W  beats in packet, saturating at MAX_BEATS.
- m_err  out  1  packet exceeded MAX_BEATS beats.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values (asserted asynchronously, released on the next clk edge):
  - state = ACCUM, s_ready = 1, m_valid = 0.
  - m_word = 0, m_parity = ODD, m_beats = 0, m_err = 0.
  - Internal acc = 0, cnt = 0, err = 0.
- FSM, two states:
  - ACCUM: s_ready = 1, m_valid = 0.
  - HOLD: s_ready = 0, m_valid = 1.
- Transfer is s_valid & s_ready; result accept is m_valid & m_ready.
- ACCUM, transfer with s_last = 0:
  - acc <= acc ^ s_data.
  - cnt <= cnt + 1, saturating at MAX_BEATS.
  - If cnt == MAX_BEATS before the increment, err <= 1.
- ACCUM, transfer with s_last = 1:
  - m_word <= acc ^ s_data; m_parity <= ^(acc ^ s_data) ^ ODD.
  - m_beats <= sat(cnt + 1); m_err <= err | (cnt == MAX_BEATS).
  - acc, cnt, err <= 0; state -> HOLD.
- Latency: result is valid on the cycle after the last beat transfers. A single-beat packet therefore gives m_valid one cycle after acceptance.
- HOLD:
  - All m_* outputs are held stable until accepted.
  - On m_ready: m_valid drops next cycle, state -> ACCUM.
  - No input is accepted in the same cycle as the accept, so there is one bubble per packet. Peak throughput is N beats per N+1 cycles.
- m_word, m_parity, m_beats and m_err keep their last values after acceptance; they are only meaningful while m_valid = 1.
- s_data and s_last are ignored when s_valid = 0.
- clear = 1 in any state: next cycle state = ACCUM, acc/cnt/err = 0, m_valid = 0. clear has priority over any simultaneous transfer or accept, and that beat/result is discarded.
- Overflow: beats beyond MAX_BEATS are still XORed into acc. m_beats saturates and m_err = 1, and the packet still completes normally on s_last.
- rst_n asserted mid-packet or while in HOLD: immediate return to reset values; the partial packet is lost.
- No combinational path from s_valid to s_ready or from m_ready to m_valid; s_ready and m_valid are decoded from registered state only.

Decomposition:
- Shared package `xor_pkg`:
  - State enum typedef {ACCUM, HOLD}.
  - Default-parameter constants.
  - Function `parity_f(word, odd)` returning (^word) ^ odd.
- Natural sub-module: `xor_fold_acc`, holding acc, cnt and err with load/clear/step controls. The top holds the FSM and output register.

Test Plan:
- DATA_W = 8, ODD = 0; beats 0x3C, 0x0F, 0xA5 (last), m_ready = 1 → m_word = 0x96, m_parity = 0, m_beats = 3, m_err = 0; m_valid asserts the cycle after 0xA5.
- ODD = 1; single beat 0x01 with s_last → m_word = 0x01, m_parity = 0, m_beats = 1; s_ready = 0 while m_valid = 1.
- m_ready held 0 for 5 cycles after result, s_valid held 1 → s_ready stays 0, outputs stable; m_ready = 1 → next packet accepted starting 2 cycles later.
- MAX_BEATS = 4; 6 beats of 0xFF, last on the 6th → m_word = 0x00, m_beats = 4, m_err = 1; next clean 2-beat packet gives m_err = 0.
- clear pulsed on the 2nd beat of a 3-beat packet (0x11, 0x22, 0x44) → 0x22 discarded; new packet 0x44 (last) gives m_word = 0x44, m_beats = 1.
- rst_n dropped asynchronously mid-cycle during HOLD → m_valid = 0 immediately with no clock edge, all outputs at reset values; resumes on release.
